// File: rtl/icache_fill.sv
// icache_fill: direct-mapped instruction cache. Hits return in the same cycle; a miss refills WORDS beats
// paced by mem_ready, with stallF high until the hit. Define ICACHE_PERF_EN to enable hit/miss counters.
module icache_fill #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pcF,
   output logic [31:0] instrF,
   output logic        stallF,
   input  logic        inv,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int LINE_W = 30 - OFF_W;
   localparam int TAG_W  = LINE_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t             state;
   logic [LINES-1:0]   valid;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [31:0]        data_mem [LINES*WORDS];
   logic [OFF_W-1:0]   beat;
   logic [LINE_W-1:0]  base_line;
   logic               inv_pend;

   logic [OFF_W-1:0]   off;
   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic [IDX_W-1:0]   ref_idx;
   logic [TAG_W-1:0]   ref_tag;
   logic               hit;
   logic               accept;
   logic               last;
   logic [1:0]         unused_byte_bits;

   assign off              = pcF[2 +: OFF_W];
   assign idx              = pcF[2+OFF_W +: IDX_W];
   assign tag              = pcF[2+OFF_W+IDX_W +: TAG_W];
   assign ref_idx          = base_line[IDX_W-1:0];
   assign ref_tag          = base_line[LINE_W-1:IDX_W];
   assign unused_byte_bits = pcF[1:0];

   always_comb begin
      hit    = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);
      accept = (state == REFILL) && mem_ready;
      last   = accept && (beat == LAST_BEAT);
      stallF = !hit;
      instrF = hit ? data_mem[{idx, off}] : 32'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         valid     <= '0;
         beat      <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         base_line <= '0;
         inv_pend  <= 1'b0;
      end else begin
         if (inv)
            valid <= '0;
         case (state)
            IDLE: begin
               if (!hit) begin
                  state     <= REFILL;
                  base_line <= pcF[31:2+OFF_W];
                  mem_addr  <= {pcF[31:2+OFF_W], {(2+OFF_W){1'b0}}};
                  mem_req   <= 1'b1;
                  beat      <= '0;
                  inv_pend  <= 1'b0;
               end
            end
            REFILL: begin
               // An invalidate seen at any point of the refill keeps the new line invalid.
               if (inv)
                  inv_pend <= 1'b1;
               if (mem_ready) begin
                  if (beat == LAST_BEAT) begin
                     state   <= IDLE;
                     mem_req <= 1'b0;
                     beat    <= '0;
                     if (!inv && !inv_pend)
                        valid[ref_idx] <= 1'b1;
                  end else begin
                     beat     <= beat + 1'b1;
                     mem_addr <= mem_addr + 32'd4;
                  end
               end
            end
         endcase
      end
   end

   // Arrays carry no reset; validity alone decides whether their contents matter.
   always_ff @(posedge clk) begin
      if (accept)
         data_mem[{ref_idx, beat}] <= mem_rdata;
      if (last)
         tag_mem[ref_idx] <= ref_tag;
   end

`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit)
            hit_count <= hit_count + 32'd1;
         if ((state == IDLE) && !hit)
            miss_count <= miss_count + 32'd1;
      end
   end
`else
   assign hit_count  = 32'd0;
   assign miss_count = 32'd0;
`endif

endmodule
